// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle between the branch resolver and its producer/consumer.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [PC_W-1:0] in_pc;
  logic [PC_W-1:0] in_imm;
  logic            in_pred_taken;
  logic [PC_W-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [PC_W-1:0] out_target;
  logic [PC_W-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;

  // Producer/consumer side
  modport master (
    output in_valid, in_funct3, in_src1, in_src2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_redirect_pc,
           out_mispredict, out_illegal
  );

  // Resolver side
  modport slave (
    input  in_valid, in_funct3, in_src1, in_src2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_redirect_pc,
           out_mispredict, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage RV32 conditional-branch resolver: compares and targets in S1, condition
// select and mispredict detection in S2, plus saturating delivery counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     br_cnt,
  output logic [CNT_W-1:0]     mispred_cnt
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [PC_W-1:0]  INSN_BYTES = PC_W'(4);

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            ready_c;
  logic            s1_adv;
  logic            accept;
  logic            deliver;

  logic            s1_valid;
  logic            s1_eq;
  logic            s1_lt;
  logic            s1_ltu;
  logic [PC_W-1:0] s1_target;
  logic [PC_W-1:0] s1_seq;
  logic [2:0]      s1_funct3;
  logic            s1_pred_taken;
  logic [PC_W-1:0] s1_pred_target;

  logic            s2_valid;
  logic            s2_taken;
  logic [PC_W-1:0] s2_target;
  logic [PC_W-1:0] s2_redirect_pc;
  logic            s2_mispredict;
  logic            s2_illegal;

  logic            taken_c;
  logic            illegal_c;
  logic            mispredict_c;
  logic [PC_W-1:0] redirect_c;

  assign src1 = bus.in_src1;
  assign src2 = bus.in_src2;

  // No skid buffer: S1 can take a new request only if it drains this cycle.
  assign s1_adv  = !s2_valid || bus.out_ready;
  assign ready_c = !s1_valid || s1_adv;
  assign accept  = bus.in_valid && ready_c && !flush;
  assign deliver = s2_valid && bus.out_ready;

  // S1: operand compares and both candidate next-PCs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_eq          <= 1'b0;
      s1_lt          <= 1'b0;
      s1_ltu         <= 1'b0;
      s1_target      <= '0;
      s1_seq         <= '0;
      s1_funct3      <= '0;
      s1_pred_taken  <= 1'b0;
      s1_pred_target <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (ready_c) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_eq          <= (src1 == src2);
        s1_lt          <= ($signed(src1) < $signed(src2));
        s1_ltu         <= (src1 < src2);
        s1_target      <= bus.in_pc + bus.in_imm;
        s1_seq         <= bus.in_pc + INSN_BYTES;
        s1_funct3      <= bus.in_funct3;
        s1_pred_taken  <= bus.in_pred_taken;
        s1_pred_target <= bus.in_pred_target;
      end
    end
  end

  // Condition select and prediction check; reserved encodings never redirect as taken
  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (s1_funct3)
      F3_BEQ:  taken_c = s1_eq;
      F3_BNE:  taken_c = !s1_eq;
      F3_BLT:  taken_c = s1_lt;
      F3_BGE:  taken_c = !s1_lt;
      F3_BLTU: taken_c = s1_ltu;
      F3_BGEU: taken_c = !s1_ltu;
      default: illegal_c = 1'b1;
    endcase
    mispredict_c = !illegal_c &&
                   ((taken_c != s1_pred_taken) ||
                    (taken_c && (s1_pred_target != s1_target)));
    redirect_c   = taken_c ? s1_target : s1_seq;
  end

  // S2: result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid       <= 1'b0;
      s2_taken       <= 1'b0;
      s2_target      <= '0;
      s2_redirect_pc <= '0;
      s2_mispredict  <= 1'b0;
      s2_illegal     <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s1_adv) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv && s1_valid && !flush) begin
        s2_taken       <= taken_c;
        s2_target      <= s1_target;
        s2_redirect_pc <= redirect_c;
        s2_mispredict  <= mispredict_c;
        s2_illegal     <= illegal_c;
      end
    end
  end

  // Delivery counters; a handshake in a flush cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (deliver) begin
      if (br_cnt != CNT_MAX) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (s2_mispredict && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready        = ready_c;
  assign bus.out_valid       = s2_valid;
  assign bus.out_taken       = s2_taken;
  assign bus.out_target      = s2_target;
  assign bus.out_redirect_pc = s2_redirect_pc;
  assign bus.out_mispredict  = s2_mispredict;
  assign bus.out_illegal     = s2_illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus randomized traffic
// with flush, back-pressure, counter clears and a mid-stream reset.
module tb_branch_resolve_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 3;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
  } req_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect;
    logic        mispredict;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   br_m = 0;
  int   mp_m = 0;

  branch_resolve_unit_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .br_cnt     (br_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: branch outcome from the ISA rules using plain integer arithmetic
  function automatic exp_t model(input req_t r);
    exp_t   e;
    bit     cond = 1'b0;
    bit     ill  = 1'b0;
    int     sa   = int'(r.s1);
    int     sb   = int'(r.s2);
    longint ua   = longint'({32'h0, r.s1});
    longint ub   = longint'({32'h0, r.s2});
    case (r.f3)
      3'd0: cond = (ua == ub);
      3'd1: cond = (ua != ub);
      3'd4: cond = (sa < sb);
      3'd5: cond = (sa >= sb);
      3'd6: cond = (ua < ub);
      3'd7: cond = (ua >= ub);
      default: ill = 1'b1;
    endcase
    e.taken      = cond;
    e.illegal    = ill;
    e.target     = r.pc + r.imm;
    e.redirect   = cond ? e.target : (r.pc + 32'd4);
    e.mispredict = !ill && ((cond != r.pt) || (cond && (r.ptgt != e.target)));
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                              input logic [31:0] ptgt);
    req_t r;
    r.f3 = f3; r.s1 = s1; r.s2 = s2; r.pc = pc; r.imm = imm; r.pt = pt; r.ptgt = ptgt;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    int   mode = int'($urandom_range(0, 3));
    r.f3  = 3'($urandom_range(0, 7));
    r.s1  = $urandom;
    case (mode)
      0:       r.s2 = r.s1;
      1:       r.s2 = r.s1 ^ 32'h8000_0000;
      2:       r.s2 = 32'($urandom_range(0, 3));
      default: r.s2 = $urandom;
    endcase
    if (mode == 2) r.s1 = 32'($urandom_range(0, 3)) - 32'd1;
    r.pc   = $urandom & 32'hFFFF_FFFC;
    r.imm  = 32'($signed(13'($urandom)));
    r.pt   = 1'($urandom_range(0, 1));
    r.ptgt = ($urandom_range(0, 1) == 1) ? (r.pc + r.imm) : $urandom;
    return r;
  endfunction

  task automatic drive(input req_t r);
    bus.in_funct3      = r.f3;
    bus.in_src1        = r.s1;
    bus.in_src2        = r.s2;
    bus.in_pc          = r.pc;
    bus.in_imm         = r.imm;
    bus.in_pred_taken  = r.pt;
    bus.in_pred_target = r.ptgt;
  endtask

  // Issue-side tracker: expected result is queued for every accepted request
  req_t tr_r;
  bit   tr_acc;
  always @(negedge clk) begin
    tr_acc = rst_n && bus.in_valid && bus.in_ready && !flush;
    tr_r   = mk(bus.in_funct3, bus.in_src1, bus.in_src2, bus.in_pc, bus.in_imm,
                bus.in_pred_taken, bus.in_pred_target);
    #1;
    if (tr_acc) exp_q.push_back(model(tr_r));
  end

  // Monitor: pops on every output handshake, checks hold, ready and counters
  exp_t mon_e;
  exp_t held;
  bit   prev_stall = 1'b0;
  bit   mon_mis;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      br_m = 0;
      mp_m = 0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!(exp_q.size() == 2 && !bus.out_ready)));
      chk("br_cnt", 32'(br_cnt), 32'(br_m));
      chk("mispred_cnt", 32'(mispred_cnt), 32'(mp_m));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_taken", 32'(bus.out_taken), 32'(held.taken));
        chk("hold_target", bus.out_target, held.target);
        chk("hold_redirect", bus.out_redirect_pc, held.redirect);
        chk("hold_mispredict", 32'(bus.out_mispredict), 32'(held.mispredict));
        chk("hold_illegal", 32'(bus.out_illegal), 32'(held.illegal));
      end
      mon_mis = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_mis = mon_e.mispredict;
          chk("taken", 32'(bus.out_taken), 32'(mon_e.taken));
          chk("target", bus.out_target, mon_e.target);
          chk("redirect", bus.out_redirect_pc, mon_e.redirect);
          chk("mispredict", 32'(bus.out_mispredict), 32'(mon_e.mispredict));
          chk("illegal", 32'(bus.out_illegal), 32'(mon_e.illegal));
        end
      end
      if (cnt_clr) begin
        br_m = 0;
        mp_m = 0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (br_m < CNT_MAX) br_m++;
        if (mon_mis && mp_m < CNT_MAX) mp_m++;
      end
      prev_stall     = bus.out_valid && !bus.out_ready && !flush;
      held.taken     = bus.out_taken;
      held.target    = bus.out_target;
      held.redirect  = bus.out_redirect_pc;
      held.mispredict = bus.out_mispredict;
      held.illegal   = bus.out_illegal;
      if (flush) exp_q.delete();
    end
  end

  // Present a request from posedge+1 until accepted; returns at posedge+1 after acceptance
  task automatic send(input req_t r);
    bit acc = 1'b0;
    drive(r);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready && !flush;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  // Single request into an empty pipe, checking N+2 latency and literal results
  task automatic send_expect(input req_t r, input logic tk, input logic [31:0] tgt,
                             input logic [31:0] rd, input logic mis, input logic ill);
    send(r);
    chk("lat_n1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("dir_taken", 32'(bus.out_taken), 32'(tk));
    chk("dir_target", bus.out_target, tgt);
    chk("dir_redirect", bus.out_redirect_pc, rd);
    chk("dir_mispredict", 32'(bus.out_mispredict), 32'(mis));
    chk("dir_illegal", 32'(bus.out_illegal), 32'(ill));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    cnt_clr       = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(mk(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0));
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_taken", 32'(bus.out_taken), 32'd0);
    chk("rst_target", bus.out_target, 32'd0);
    chk("rst_redirect", bus.out_redirect_pc, 32'd0);
    chk("rst_mis_ill", 32'({bus.out_mispredict, bus.out_illegal}), 32'd0);
    chk("rst_counters", 32'({br_cnt, mispred_cnt}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Signed vs unsigned compare on the same operands
    send_expect(mk(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0),
                1'b1, 32'h120, 32'h120, 1'b1, 1'b0);
    send_expect(mk(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0),
                1'b0, 32'h120, 32'h104, 1'b0, 1'b0);
    // Correct direction but wrong target, then fully correct
    send_expect(mk(3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b1, 32'h200),
                1'b1, 32'h140, 32'h140, 1'b1, 1'b0);
    send_expect(mk(3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b1, 32'h140),
                1'b1, 32'h140, 32'h140, 1'b0, 1'b0);
    // Reserved funct3 with PC wrap
    send_expect(mk(3'b010, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'd4),
                1'b0, 32'h4, 32'h0, 1'b0, 1'b1);
    drain();

    // Back-pressure: four BNE back-to-back with the consumer stalled
    clear_counters();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(mk(3'b001, 32'(k), 32'(k * 3), 32'h1000 + 32'(k * 4), 32'h80, 1'b1, 32'h0));
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_br_cnt", 32'(br_cnt), 32'd4);

    // Flush while the second request sits in S2; its handshake still counts
    clear_counters();
    send(mk(3'b101, 32'd7, 32'd3, 32'h2000, 32'h10, 1'b0, 32'h0));
    send(mk(3'b111, 32'd2, 32'd9, 32'h2004, 32'h10, 1'b0, 32'h0));
    @(posedge clk); #1;
    drive(mk(3'b000, 32'd1, 32'd1, 32'h3000, 32'h8, 1'b0, 32'h0));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_dropped", 32'(bus.out_valid), 32'd0);
    chk("flush_br_cnt", 32'(br_cnt), 32'd2);

    // Saturation, then clear coinciding with a handshake
    clear_counters();
    for (int k = 0; k < 9; k++)
      send(mk(3'b000, 32'(k), 32'(k), 32'h4000, 32'h20, 1'b0, 32'h0));
    drain();
    chk("sat_mispred_cnt", 32'(mispred_cnt), 32'(CNT_MAX));
    chk("sat_br_cnt", 32'(br_cnt), 32'(CNT_MAX));
    send(mk(3'b001, 32'd1, 32'd1, 32'h4000, 32'h20, 1'b1, 32'h4020));
    @(posedge clk); #1;
    chk("clr_hs_valid", 32'(bus.out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_hs_br_cnt", 32'(br_cnt), 32'd0);
    chk("clr_hs_mispred_cnt", 32'(mispred_cnt), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      drive(rnd_req());
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 49) == 0);
      cnt_clr       = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end

    // Mid-stream asynchronous reset with a stalled, full pipe
    flush = 1'b0;
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(rnd_req());
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_counters", 32'({br_cnt, mispred_cnt}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst2", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 300; c++) begin
      drive(rnd_req());
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 39) == 0);
      cnt_clr       = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
